ucode_fetch_ctrl: RTL

UCODE_FETCH_CTRL -- requirements
Module: ucode_fetch_ctrl

---
 rtl/pkg_ucode_decoder.sv | 36 +++
 rtl/ucode_loop_stack.sv | 98 +++++++++
 rtl/ucode_fetch_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pkg_ucode_decoder.sv
// Shared microcode instruction format plus the fetch-controller FSM state type.
// Instruction word: {nisc, opcode, reserved, operand}, operand = {operand_a, operand_b}.
package pkg_ucode_decoder;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int OPERAND_WIDTH     = 20;
    localparam int OPA_WIDTH         = 10;
    localparam int OPB_WIDTH         = 10;
    localparam int NUM_LOOPS         = 3;

    typedef enum logic [3:0] {
        OP_NOP         = 4'h0,
        OP_JMP         = 4'h1,
        OP_LOOP_SETUP0 = 4'h2,
        OP_LOOP_SETUP1 = 4'h3,
        OP_LOOP_SETUP2 = 4'h4,
        OP_ALU         = 4'h5,
        OP_MOVE        = 4'h6
    } opcode_t;

    typedef struct packed {
        logic                     nisc;
        opcode_t                  opcode;
        logic [6:0]               rsvd;
        logic [OPERAND_WIDTH-1:0] operand;
    } instruction_t;

    // One-hot apart from IDLE so each FSM output is a single flop bit.
    typedef enum logic [2:0] {
        FS_IDLE  = 3'b000,
        FS_FETCH = 3'b001,
        FS_EVAL  = 3'b010,
        FS_ISSUE = 3'b100
    } fetch_state_e;

endpackage

// File: rtl/ucode_loop_stack.sv
// Program counter and three-level hardware loop registers with the next-PC rule.
// Loop 0 is innermost; a loop at its end with a zero count retires and defers outward.
module ucode_loop_stack
    import pkg_ucode_decoder::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  advance_i,
    input  logic [NUM_LOOPS-1:0]  setup_sel_i,
    input  logic [OPA_WIDTH-1:0]  setup_count_i,
    input  logic [ADDR_WIDTH-1:0] setup_end_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0]                 pc_q, pc_d;
    logic [NUM_LOOPS-1:0][OPA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_LOOPS-1:0][ADDR_WIDTH-1:0]  end_q, end_d;
    logic [NUM_LOOPS-1:0][ADDR_WIDTH-1:0]  start_q, start_d;
    logic [NUM_LOOPS-1:0]                  active_q, active_d;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [NUM_LOOPS-1:0]  retire;
    logic [NUM_LOOPS-1:0]  hit;
    logic                  found;

    // Next-PC evaluation reads only the registered loop state, never a same-cycle setup.
    always_comb begin
        pc_inc  = pc_q + ADDR_WIDTH'(1);
        next_pc = pc_inc;
        retire  = '0;
        hit     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            if (!found && active_q[k] && (pc_q == end_q[k])) begin
                if (cnt_q[k] != '0) begin
                    found   = 1'b1;
                    hit[k]  = 1'b1;
                    next_pc = start_q[k];
                end else begin
                    retire[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        end_d    = end_q;
        start_d  = start_q;
        active_d = active_q;
        if (clear_i) begin
            active_d = '0;
        end
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (advance_i) begin
            pc_d = next_pc;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                if (retire[k]) active_d[k] = 1'b0;
                if (hit[k])    cnt_d[k]    = cnt_q[k] - OPA_WIDTH'(1);
            end
        end
        for (int k = 0; k < NUM_LOOPS; k++) begin
            if (setup_sel_i[k]) begin
                cnt_d[k]    = (setup_count_i == '0) ? '0 : setup_count_i - OPA_WIDTH'(1);
                end_d[k]    = setup_end_i;
                start_d[k]  = pc_inc;
                active_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            end_q    <= '0;
            start_q  <= '0;
            active_q <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            end_q    <= end_d;
            start_q  <= start_d;
            active_q <= active_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ucode_fetch_ctrl.sv
// Microcode fetch controller: FETCH/EVAL/ISSUE sequencing and the instruction register.
// Jumps and loop setups are consumed here; everything else is handed to the decoder.
module ucode_fetch_ctrl
    import pkg_ucode_decoder::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [ADDR_WIDTH-1:0]        start_addr_i,
    input  logic                         stop_i,
    output logic                         mem_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata_i,
    output logic [INSTRUCTION_WIDTH-1:0] instr_o,
    output logic                         instr_valid_o,
    input  logic                         instr_ready_i,
    output logic                         busy_o
);

    fetch_state_e                 state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    instruction_t                 rdata;

    logic                  ls_clear;
    logic                  ls_load;
    logic [ADDR_WIDTH-1:0] ls_load_addr;
    logic                  ls_advance;
    logic [NUM_LOOPS-1:0]  ls_setup;
    logic [ADDR_WIDTH-1:0] pc;

    logic unused_rsvd;

    assign rdata       = instruction_t'(mem_rdata_i);
    assign unused_rsvd = ^rdata.rsvd;

    ucode_loop_stack #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_loop_stack (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (ls_clear),
        .load_i        (ls_load),
        .load_addr_i   (ls_load_addr),
        .advance_i     (ls_advance),
        .setup_sel_i   (ls_setup),
        .setup_count_i (rdata.operand[OPERAND_WIDTH-1 -: OPA_WIDTH]),
        .setup_end_i   (ADDR_WIDTH'(rdata.operand[OPB_WIDTH-1:0])),
        .pc_o          (pc)
    );

    // NOTE: <= in clocked blocks so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FS_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        ls_clear     = 1'b0;
        ls_load      = 1'b0;
        ls_load_addr = start_addr_i;
        ls_advance   = 1'b0;
        ls_setup     = '0;
        unique case (state_q)
            FS_IDLE: begin
                if (start_i) begin
                    ls_clear = 1'b1;
                    ls_load  = 1'b1;
                    state_d  = FS_FETCH;
                end
            end
            FS_FETCH: state_d = FS_EVAL;
            FS_EVAL: begin
                instr_d = mem_rdata_i;
                state_d = FS_FETCH;
                if (rdata.nisc) begin
                    state_d = FS_ISSUE;
                end else begin
                    case (rdata.opcode)
                        OP_JMP: begin
                            ls_load      = 1'b1;
                            ls_load_addr = ADDR_WIDTH'(rdata.operand);
                        end
                        OP_LOOP_SETUP0: begin ls_setup = 3'b001; ls_advance = 1'b1; end
                        OP_LOOP_SETUP1: begin ls_setup = 3'b010; ls_advance = 1'b1; end
                        OP_LOOP_SETUP2: begin ls_setup = 3'b100; ls_advance = 1'b1; end
                        default:        state_d = FS_ISSUE;
                    endcase
                end
            end
            FS_ISSUE: begin
                if (instr_ready_i) begin
                    ls_advance = 1'b1;
                    state_d    = FS_FETCH;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        // Abort wins over start, handshake and any loop update; the PC is left alone.
        if (stop_i) begin
            state_d    = FS_IDLE;
            ls_clear   = 1'b1;
            ls_load    = 1'b0;
            ls_advance = 1'b0;
            ls_setup   = '0;
        end
    end

    // Outputs come straight from flop bits so an asynchronous reset cannot glitch them high.
    always_comb begin
        mem_req_o     = state_q[0];
        instr_valid_o = state_q[2];
        busy_o        = |state_q;
        mem_addr_o    = pc;
        instr_o       = instr_q;
    end

endmodule
